// File: rtl/pole_fmult.sv
`default_nettype none
// ============================================================================
//  Module   : pole_fmult
//  Brief    : ADPCM two-tap pole predictor section. Shifts the SR delay line,
//             forms WA1/WA2 with one shared G.726 floating multiplier and sums
//             them into SEPI.
//  Revision : 1.0 - initial release
// ============================================================================
module pole_fmult (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  input  logic        start,
  input  logic [10:0] SR0,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  output logic        busy,
  output logic        done,
  output logic [10:0] SR1,
  output logic [10:0] SR2,
  output logic [15:0] WA1,
  output logic [15:0] WA2,
  output logic [15:0] SEPI
);

  localparam logic [10:0] c_float_zero = 11'h020;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL1 = 2'd1,
    S_MUL2 = 2'd2,
    S_SUM  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [10:0] r_sr1, r_sr2;
  logic [15:0] r_a1q, r_a2q;
  logic [15:0] r_wa1, r_wa2, r_sepi;
  logic        r_done;

  // Scan chain is stitched at integration; the block itself only ties off.
  wire w_unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Exponent of a 13-bit magnitude: position of the top set bit plus one.
  function automatic logic [3:0] f_exp13(input logic [12:0] m);
    logic [3:0] e;
    e = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (m[i]) e = 4'(i + 1);
    end
    return e;
  endfunction

  // ---------------------------------------------------------------- FMULT
  logic [15:0] w_an;
  logic [10:0] w_srn;
  logic        w_an_sign;
  logic [12:0] w_an_mag;
  logic [3:0]  w_an_exp;
  logic [18:0] w_an_norm;
  logic [5:0]  w_an_mant;
  logic        w_ws;
  logic [4:0]  w_wexp;
  logic [7:0]  w_wmant;
  logic [14:0] w_wm_base;
  logic [14:0] w_wmag;
  logic [15:0] w_fmult;

  assign w_an  = (r_state == S_MUL1) ? r_a1q : r_a2q;
  assign w_srn = (r_state == S_MUL1) ? r_sr1 : r_sr2;

  assign w_an_sign = w_an[15];
  // Only the low 13 bits of the negated coefficient survive the mask.
  assign w_an_mag  = w_an_sign ? (13'd0 - w_an[14:2]) : w_an[14:2];
  assign w_an_exp  = f_exp13(w_an_mag);
  assign w_an_norm = {w_an_mag, 6'b0} >> w_an_exp;
  assign w_an_mant = (w_an_mag == 13'd0) ? 6'd32 : w_an_norm[5:0];

  assign w_ws      = w_srn[10] ^ w_an_sign;
  assign w_wexp    = {1'b0, w_srn[9:6]} + {1'b0, w_an_exp};
  assign w_wmant   = 8'(({7'b0, w_srn[5:0]} * {7'b0, w_an_mant} + 13'd48) >> 4);
  assign w_wm_base = {w_wmant, 7'b0};
  // Exponents 27/28 shift left inside 15 bits, so the top bits fall off.
  assign w_wmag    = (w_wexp <= 5'd26) ? (w_wm_base >> (5'd26 - w_wexp))
                                       : (w_wm_base << (w_wexp - 5'd26));
  assign w_fmult   = w_ws ? (16'd0 - {1'b0, w_wmag}) : {1'b0, w_wmag};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_MUL1;
      S_MUL1:  w_state_next = S_MUL2;
      S_MUL2:  w_state_next = S_SUM;
      S_SUM:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr1  <= c_float_zero;
      r_sr2  <= c_float_zero;
      r_a1q  <= 16'd0;
      r_a2q  <= 16'd0;
      r_wa1  <= 16'd0;
      r_wa2  <= 16'd0;
      r_sepi <= 16'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr2 <= r_sr1;
            r_sr1 <= SR0;
            r_a1q <= A1;
            r_a2q <= A2;
          end
        end
        S_MUL1: r_wa1 <= w_fmult;
        S_MUL2: r_wa2 <= w_fmult;
        S_SUM: begin
          r_sepi <= r_wa1 + r_wa2;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign SR1  = r_sr1;
  assign SR2  = r_sr2;
  assign WA1  = r_wa1;
  assign WA2  = r_wa2;
  assign SEPI = r_sepi;

endmodule
`default_nettype wire

// File: tb/tb_pole_fmult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pole_fmult
//  Brief    : Self-checking bench for pole_fmult: vector table, corner-case
//             sequences and random samples against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pole_fmult;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_enable, test_mode;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic        start;
  logic [10:0] SR0;
  logic [15:0] A1, A2;
  logic        busy, done;
  logic [10:0] SR1, SR2;
  logic [15:0] WA1, WA2, SEPI;

  always #5 clk = ~clk;

  pole_fmult dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .start(start), .SR0(SR0), .A1(A1), .A2(A2),
    .busy(busy), .done(done), .SR1(SR1), .SR2(SR2),
    .WA1(WA1), .WA2(WA2), .SEPI(SEPI)
  );

  typedef struct {
    logic [10:0] sr0;
    logic [15:0] a1, a2;
    logic [10:0] sr1, sr2;
    logic [15:0] wa1, wa2, sepi;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  logic [10:0] m_sr1, m_sr2;
  logic [15:0] m_wa1, m_wa2, m_sepi;

  function automatic logic [15:0] fmult(input logic [15:0] an, input logic [10:0] srn);
    int a, s, mag, aexp, amant, sexp, smant, ws, wexp, wmant, wmag;
    a     = int'(an);
    s     = int'(an[15]);
    mag   = (s != 0) ? ((-(a >> 2)) & 'h1FFF) : (a >> 2);
    aexp  = 0;
    for (int b = 0; b < 13; b++) if (((mag >> b) & 1) != 0) aexp = b + 1;
    amant = (mag == 0) ? 32 : ((mag << 6) >> aexp);
    sexp  = int'(srn[9:6]);
    smant = int'(srn[5:0]);
    ws    = s ^ int'(srn[10]);
    wexp  = sexp + aexp;
    wmant = (smant * amant + 48) >> 4;
    wmag  = (wexp <= 26) ? ((wmant << 7) >> (26 - wexp))
                         : (((wmant << 7) << (wexp - 26)) & 'h7FFF);
    return (ws != 0) ? 16'((-wmag) & 'hFFFF) : 16'(wmag);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic [10:0] sr0_v, input logic [15:0] a1_v, input logic [15:0] a2_v);
    m_sr2  = m_sr1;
    m_sr1  = sr0_v;
    m_wa1  = fmult(a1_v, m_sr1);
    m_wa2  = fmult(a2_v, m_sr2);
    m_sepi = m_wa1 + m_wa2;
  endtask

  // One full sample: pulse start, scramble the inputs, wait for done.
  task automatic run_sample(input logic [10:0] sr0_v, input logic [15:0] a1_v, input logic [15:0] a2_v);
    int   cyc;
    logic busy_ok;
    SR0 = sr0_v; A1 = a1_v; A2 = a2_v; start = 1'b1;
    tick;
    start = 1'b0;
    model_accept(sr0_v, a1_v, a2_v);
    SR0 = 11'($urandom); A1 = 16'($urandom); A2 = 16'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 8) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick;
      cyc++;
    end
    check("done_latency", 16'(cyc), 16'd4);
    check("busy_during", {15'd0, busy_ok}, 16'd1);
    check("busy_at_done", {15'd0, busy}, 16'd0);
    check("SR1", {5'd0, SR1}, {5'd0, m_sr1});
    check("SR2", {5'd0, SR2}, {5'd0, m_sr2});
    check("WA1", WA1, m_wa1);
    check("WA2", WA2, m_wa2);
    check("SEPI", SEPI, m_sepi);
    tick;
    check("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  initial begin
    vecs[0] = '{11'h2BE, 16'h4000, 16'hC000, 11'h2BE, 11'h020, 16'h07F0, 16'hFFFF, 16'h07EF};
    vecs[1] = '{11'h2BE, 16'h4000, 16'hC000, 11'h2BE, 11'h2BE, 16'h07F0, 16'hF810, 16'h0000};
    vecs[2] = '{11'h155, 16'h0000, 16'h0000, 11'h155, 11'h2BE, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{11'h3FF, 16'h7FFF, 16'h0000, 11'h3FF, 11'h155, 16'h7600, 16'h0000, 16'h7600};
    vecs[4] = '{11'h7BE, 16'h2000, 16'hFFFC, 11'h7BE, 11'h3FF, 16'hC080, 16'hFFF0, 16'hC070};

    reset = 1'b1; start = 1'b0; SR0 = '0; A1 = '0; A2 = '0;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b10101;
    scan_enable = 1'b0; test_mode = 1'b0;
    m_sr1 = 11'h020; m_sr2 = 11'h020;
    tick; tick;
    reset = 1'b0;

    // Reset state
    check("rst_SR1", {5'd0, SR1}, 16'h0020);
    check("rst_SR2", {5'd0, SR2}, 16'h0020);
    check("rst_WA1", WA1, 16'h0000);
    check("rst_WA2", WA2, 16'h0000);
    check("rst_SEPI", SEPI, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_scan_out", {11'd0, scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 16'd0);

    // Known-answer vectors, delay line carried from row to row
    for (int i = 0; i < 5; i++) begin
      run_sample(vecs[i].sr0, vecs[i].a1, vecs[i].a2);
      check($sformatf("vec%0d_SR1", i), {5'd0, SR1}, {5'd0, vecs[i].sr1});
      check($sformatf("vec%0d_SR2", i), {5'd0, SR2}, {5'd0, vecs[i].sr2});
      check($sformatf("vec%0d_WA1", i), WA1, vecs[i].wa1);
      check($sformatf("vec%0d_WA2", i), WA2, vecs[i].wa2);
      check($sformatf("vec%0d_SEPI", i), SEPI, vecs[i].sepi);
    end

    // start held high every cycle: one sample accepted per 4 clocks
    for (int k = 0; k < 16; k++) begin
      logic [10:0] s0;
      logic [15:0] c1, c2;
      s0 = 11'($urandom); c1 = 16'($urandom); c2 = 16'($urandom);
      SR0 = s0; A1 = c1; A2 = c2; start = 1'b1;
      tick;
      if (k % 4 == 0) model_accept(s0, c1, c2);
      check($sformatf("b2b%0d_busy", k), {15'd0, busy}, {15'd0, (k % 4 != 3)});
      check($sformatf("b2b%0d_done", k), {15'd0, done}, {15'd0, (k % 4 == 3)});
      check($sformatf("b2b%0d_SR1", k), {5'd0, SR1}, {5'd0, m_sr1});
      check($sformatf("b2b%0d_SR2", k), {5'd0, SR2}, {5'd0, m_sr2});
      if (k % 4 == 3) begin
        check($sformatf("b2b%0d_WA1", k), WA1, m_wa1);
        check($sformatf("b2b%0d_WA2", k), WA2, m_wa2);
        check($sformatf("b2b%0d_SEPI", k), SEPI, m_sepi);
      end
    end
    start = 1'b0;
    tick;

    // Reset while in MUL2: sample discarded, no done pulse
    begin
      int dones;
      SR0 = 11'h2BE; A1 = 16'h4000; A2 = 16'hC000; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("rstmid_busy", {15'd0, busy}, 16'd0);
      check("rstmid_done", {15'd0, done}, 16'd0);
      check("rstmid_SR1", {5'd0, SR1}, 16'h0020);
      check("rstmid_SR2", {5'd0, SR2}, 16'h0020);
      check("rstmid_WA1", WA1, 16'h0000);
      dones = 0;
      for (int k = 0; k < 5; k++) begin
        if (done !== 1'b0) dones++;
        tick;
      end
      check("rstmid_no_done", 16'(dones), 16'd0);
      m_sr1 = 11'h020; m_sr2 = 11'h020;
    end

    // Random samples against the model
    for (int n = 0; n < 150; n++) begin
      run_sample(11'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
